// File: rtl/comp_tally_display_if.sv
// comp_tally_display_if: comparator inputs, tally controls and display outputs of comp_tally_display.
interface comp_tally_display_if #(
    parameter int N_IN = 5
);
    logic [N_IN-1:0] comps;
    logic            hold;
    logic            clear_peak;
    logic            show_peak;
    logic [6:0]      count;
    logic [6:0]      peak;
    logic [6:0]      segs;
    logic [1:0]      digit_en;

    modport master (output comps, hold, clear_peak, show_peak, input count, peak, segs, digit_en);
    modport slave  (input comps, hold, clear_peak, show_peak, output count, peak, segs, digit_en);
endinterface

// File: rtl/comp_tally_display.sv
// comp_tally_display: debounced comparator tally with peak hold, shown on a 2-digit multiplexed 7-segment display.
module comp_tally_display #(
    parameter int N_IN           = 5,
    parameter int DEB_CYCLES     = 4,
    parameter int SCAN_DIV       = 1000,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input logic                 clk,
    input logic                 rst_n,
    comp_tally_display_if.slave bus
);
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW != 0 ? 7'h7F : 7'h00;

    logic [N_IN-1:0] r_s1, r_s2, r_d;
    logic [7:0]      r_deb [N_IN];
    logic [6:0]      r_count, r_peak, r_segs;
    logic [1:0]      r_dig;
    logic [15:0]     r_scan;
    logic [6:0]      w_pop, w_val, w_lit, w_hi;
    logic [3:0]      w_tens, w_units, w_digit;
    logic            w_show_tens;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_d  <= '0;
            for (int i = 0; i < N_IN; i++) r_deb[i] <= '0;
        end else begin
            r_s1 <= bus.comps;
            r_s2 <= r_s1;
            for (int i = 0; i < N_IN; i++) begin
                r_deb[i] <= (r_s2[i] == r_d[i] || r_deb[i] == 8'(DEB_CYCLES - 1)) ? '0 : r_deb[i] + 8'd1;
                r_d[i]   <= (r_s2[i] != r_d[i] && r_deb[i] == 8'(DEB_CYCLES - 1)) ? r_s2[i] : r_d[i];
            end
        end
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < N_IN; i++) w_pop = w_pop + 7'(r_d[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_peak  <= '0;
        end else if (!bus.hold) begin
            r_count <= w_pop;
            r_peak  <= (bus.clear_peak || w_pop > r_peak) ? w_pop : r_peak;
        end
    end

    // segs is loaded for the digit that digit_en is about to select, so both flip together
    always_comb begin
        w_val       = bus.show_peak ? r_peak : r_count;
        w_tens      = 4'(w_val / 7'd10);
        w_units     = 4'(w_val % 7'd10);
        w_show_tens = r_dig[0];
        w_digit     = w_show_tens ? w_tens : w_units;
        case (w_digit)
            4'd0:    w_hi = 7'h7E;
            4'd1:    w_hi = 7'h30;
            4'd2:    w_hi = 7'h6D;
            4'd3:    w_hi = 7'h79;
            4'd4:    w_hi = 7'h33;
            4'd5:    w_hi = 7'h5B;
            4'd6:    w_hi = 7'h5F;
            4'd7:    w_hi = 7'h70;
            4'd8:    w_hi = 7'h7F;
            default: w_hi = 7'h7B;
        endcase
        w_lit = (w_show_tens && w_tens == 4'd0) ? 7'h00 : w_hi;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan <= '0;
            r_dig  <= 2'b01;
            r_segs <= SEG_OFF;
        end else if (r_scan == 16'(SCAN_DIV - 1)) begin
            r_scan <= '0;
            r_dig  <= {r_dig[0], r_dig[1]};
            r_segs <= SEG_ACTIVE_LOW != 0 ? ~w_lit : w_lit;
        end else begin
            r_scan <= r_scan + 16'd1;
        end
    end

    assign bus.count    = r_count;
    assign bus.peak     = r_peak;
    assign bus.segs     = r_segs;
    assign bus.digit_en = r_dig;
endmodule

// File: tb/tb_comp_tally_display.sv
// tb_comp_tally_display: directed and randomized checks of comp_tally_display against a cycle-level reference model.
module tb_comp_tally_display;
    localparam int N    = 5;
    localparam int DEB  = 4;
    localparam int DIV  = 8;
    localparam int NB   = 20;
    localparam int DEBB = 2;
    localparam int DIVB = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    comp_tally_display_if #(.N_IN(N))  ifa ();
    comp_tally_display_if #(.N_IN(NB)) ifb ();

    comp_tally_display #(.N_IN(N), .DEB_CYCLES(DEB), .SCAN_DIV(DIV), .SEG_ACTIVE_LOW(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa)
    );
    comp_tally_display #(.N_IN(NB), .DEB_CYCLES(DEBB), .SCAN_DIV(DIVB), .SEG_ACTIVE_LOW(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb)
    );

    int checks = 0;
    int errors = 0;
    int m_s1 [N];
    int m_s2 [N];
    int m_d  [N];
    int m_run[N];
    int m_cnt, m_peak, m_scan, m_dig;
    logic [6:0] m_segs;
    logic [6:0] seg_hi [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
    int seen, n;
    logic [1:0] prev_en;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Active-low pattern for a value on the chosen digit, tens blanked below 10
    function automatic logic [6:0] seg_of(input int v, input bit tens_sel);
        if (tens_sel && v < 10) return 7'h7F;
        return ~(tens_sel ? seg_hi[v / 10] : seg_hi[v % 10]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_d[i] = 0; m_run[i] = 0;
        end
        m_cnt = 0; m_peak = 0; m_scan = 0; m_dig = 0; m_segs = 7'h7F;
    endtask

    task automatic model_step();
        int pop = 0;
        for (int i = 0; i < N; i++) pop += m_d[i];
        for (int i = 0; i < N; i++) begin
            if (m_s2[i] == m_d[i]) m_run[i] = 0;
            else if (m_run[i] + 1 == DEB) begin
                m_d[i] = m_s2[i];
                m_run[i] = 0;
            end else m_run[i]++;
            m_s2[i] = m_s1[i];
            m_s1[i] = int'(ifa.comps[i]);
        end
        if (m_scan == DIV - 1) begin
            m_scan = 0;
            m_segs = seg_of(ifa.show_peak ? m_peak : m_cnt, m_dig == 0);
            m_dig ^= 1;
        end else m_scan++;
        if (!ifa.hold) begin
            m_peak = (ifa.clear_peak || pop > m_peak) ? pop : m_peak;
            m_cnt = pop;
        end
    endtask

    task automatic check_all();
        chk("count", ifa.count, m_cnt);
        chk("peak", ifa.peak, m_peak);
        chk("segs", ifa.segs, m_segs);
        chk("digit_en", ifa.digit_en, m_dig != 0 ? 2'b10 : 2'b01);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic run_to_units();
        for (int k = 0; k < 2 * DIV; k++) begin
            tick();
            if (m_scan == 0 && m_dig == 0) break;
        end
    endtask

    initial begin
        ifa.comps = '0; ifa.hold = 0; ifa.clear_peak = 0; ifa.show_peak = 0;
        ifb.comps = '0; ifb.hold = 0; ifb.clear_peak = 0; ifb.show_peak = 0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_all();
        chk("rst_segs_off", ifa.segs, 7'h7F);
        #4 rst_n = 1;
        ticks(DIV);
        chk("tens_blank", ifa.segs, 7'h7F);
        chk("tens_sel", ifa.digit_en, 2'b10);
        ticks(DIV);
        chk("units_zero", ifa.segs, 7'h01);

        ifa.comps = 5'b10110;
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk($sformatf("latency_edge%0d", k), ifa.count, k < 7 ? 0 : 3);
        end
        run_to_units();
        chk("units_three", ifa.segs, 7'h06);

        ifa.comps[0] = 1'b1;
        ticks(3);
        ifa.comps[0] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("glitch3_ignored", ifa.count, 3);
        end
        seen = 0;
        ifa.comps[0] = 1'b1;
        ticks(4);
        ifa.comps[0] = 1'b0;
        for (int k = 0; k < 14; k++) begin
            tick();
            if (ifa.count == 7'd4) seen = 1;
        end
        chk("pulse4_counted", seen, 1);

        ifa.comps = 5'b00011; ticks(10);
        ifa.comps = 5'b11111; ticks(10);
        ifa.comps = 5'b00001; ticks(10);
        chk("step_count", ifa.count, 1);
        chk("step_peak", ifa.peak, 5);
        ifa.hold = 1; ifa.comps = 5'b01111; ticks(10);
        ifa.clear_peak = 1; tick(); ifa.clear_peak = 0;
        chk("hold_count", ifa.count, 1);
        chk("hold_peak", ifa.peak, 5);
        ifa.hold = 0; ticks(10);
        chk("release_count", ifa.count, 4);
        chk("release_peak", ifa.peak, 5);
        ifa.clear_peak = 1; tick(); ifa.clear_peak = 0;
        chk("clear_peak", ifa.peak, 4);

        ifa.show_peak = 1; ifa.comps = 5'b00001; ticks(10);
        run_to_units();
        chk("show_peak_units", ifa.segs, 7'h4C);
        ifa.show_peak = 0;

        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(3) == 0) begin
                n = int'($urandom_range(N - 1));
                ifa.comps[n] = ~ifa.comps[n];
            end
            ifa.hold = ($urandom_range(7) == 0);
            ifa.clear_peak = ($urandom_range(15) == 0);
            if ($urandom_range(31) == 0) ifa.show_peak = ~ifa.show_peak;
            tick();
        end

        ifa.hold = 0; ifa.clear_peak = 0; ifa.show_peak = 0; ifa.comps = '0;
        ticks(10);
        ifa.comps = 5'b00111;
        ticks(4);
        #2 rst_n = 0;
        #1;
        model_reset();
        check_all();
        chk("async_count", ifa.count, 0);
        chk("async_segs", ifa.segs, 7'h7F);
        #2 rst_n = 1;
        ticks(6);
        chk("restart_not_yet", ifa.count, 0);
        tick();
        chk("restart_count", ifa.count, 3);

        ifb.comps = '1;
        repeat (10) @(posedge clk);
        #1;
        chk("b_count", ifb.count, 20);
        chk("b_peak", ifb.peak, 20);
        prev_en = ifb.digit_en; n = 0;
        while (ifb.digit_en == prev_en && n < 20) begin
            @(posedge clk); #1; n++;
        end
        for (int p = 0; p < 2; p++) begin
            prev_en = ifb.digit_en; n = 0;
            while (ifb.digit_en == prev_en && n < 20) begin
                @(posedge clk); #1; n++;
            end
            chk("b_period", n, DIVB);
            chk("b_alternate", ifb.digit_en, {prev_en[0], prev_en[1]});
            chk("b_segs", ifb.segs, ifb.digit_en == 2'b10 ? 7'h12 : 7'h01);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
